// File: rtl/dmem_pkg.sv
// Shared types for the data memory: access-size encodings, controller states
// and the size-to-byte-count helper.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      RESP  = 2'd2
   } state_e;

   function automatic int unsigned size_bytes(input logic [1:0] sz);
      return 32'd1 << sz;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_if #(parameter int XLEN = 64);
   // A transfer happens on a rising edge where valid and ready are both high;
   // the sender holds its payload stable while valid is high and ready is low.
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and data shift, load extract with
// sign/zero extension. Purely combinational, little-endian.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter  int XLEN = 64,
   localparam int NB   = XLEN / 8,
   localparam int OFFW = $clog2(NB)
) (
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   input  logic [OFFW-1:0] offset,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [NB-1:0]   be,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata
);

   always_comb begin
      int              off;
      int              nb;
      int              sz_bits;
      logic [XLEN-1:0] shifted;
      logic [XLEN-1:0] mask;
      off      = int'(offset);
      nb       = int'(size_bytes(size));
      sz_bits  = nb * 8;
      be       = '0;
      mask     = '1;
      wdata_sh = wdata << {offset, 3'b000};
      shifted  = rword >> {offset, 3'b000};
      rdata    = shifted;
      for (int i = 0; i < NB; i++) begin
         be[i] = (i >= off) && (i < off + nb);
      end
      if (sz_bits < XLEN) begin
         mask  = {XLEN{1'b1}} >> (XLEN - sz_bits);
         rdata = shifted & mask;
         // mask ^ (mask >> 1) isolates the top bit of the access
         if (!is_unsigned && ((shifted & (mask ^ (mask >> 1))) != '0)) begin
            rdata = rdata | ~mask;
         end
      end
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with zero-fill sweep after reset, registered
// responses and misalignment/range error reporting.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 1024
) (
   input  logic   clk,
   input  logic   rst_n,
   dmem_if.slave  bus,
   output logic   init_done,
   output state_e dbg_state
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   clr_cnt_q;
   logic              init_done_q;
   logic [XLEN-1:0]   rdata_q;
   logic              err_q;
   logic [XLEN-1:0]   mem [DEPTH];

   logic              accept;
   logic              misalign, out_of_range, bad_size, err;
   logic [OFFW-1:0]   offset;
   logic [IDXW-1:0]   idx;
   logic [NB-1:0]     be;
   logic [XLEN-1:0]   wdata_sh;
   logic [XLEN-1:0]   load_ext;

   assign offset       = bus.req_addr[OFFW-1:0];
   assign idx          = bus.req_addr[OFFW +: IDXW];
   assign out_of_range = (bus.req_addr >> (OFFW + IDXW)) != '0;
   assign bad_size     = (XLEN == 32) && (bus.req_size == SZ_D);
   assign misalign     = (offset & OFFW'(size_bytes(bus.req_size) - 32'd1)) != '0;
   assign err          = misalign || out_of_range || bad_size;
   assign accept       = bus.req_valid && bus.req_ready;

   dmem_lane_align #(.XLEN(XLEN)) u_align (
      .size        (bus.req_size),
      .is_unsigned (bus.req_unsigned),
      .offset      (offset),
      .wdata       (bus.req_wdata),
      .rword       (mem[idx]),
      .be          (be),
      .wdata_sh    (wdata_sh),
      .rdata       (load_ext)
   );

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      case (state_q)
         CLEAR: if (clr_cnt_q == IDXW'(DEPTH - 1)) state_d = IDLE;
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = RESP;
         end
         RESP: begin
            // Consumer draining the response frees the slot in the same cycle
            bus.req_ready = bus.rsp_ready;
            if (bus.rsp_ready && !bus.req_valid) state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + IDXW'(1);
            if (clr_cnt_q == IDXW'(DEPTH - 1)) init_done_q <= 1'b1;
         end
         if (accept) begin
            err_q   <= err;
            rdata_q <= (err || bus.req_we) ? '0 : load_ext;
         end
      end
   end

   // Storage carries no reset; the sweep establishes its contents
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_cnt_q] <= '0;
      end else if (accept && bus.req_we && !err) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign init_done     = init_done_q;
   assign dbg_state     = state_q;

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressable data memory for the sequential RISC-V core. It replaces the fixed 64-bit, doubleword-only store with several additions:
- XLEN-generic width and configurable depth.
- Byte/half/word/double loads and stores, with sign or zero extension.
- Registered read data and a valid/ready request/response handshake with backpressure.
- Misalignment and range error reporting.
- A hardware zero-fill sweep after reset.

It sits between the core's MEM stage and the load/writeback path.

## Interface
- XLEN, 64, data width in bits; legal values are 32 and 64.
- DEPTH, 1024, number of XLEN-wide words; must be a power of two.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, taken from the low bytes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  load result after extension; 0 for stores and errors.
- rsp_err  out  1  request was rejected (misaligned, out of range, or illegal size).
- init_done  out  1  zero-fill sweep complete.

## Operation
- FSM has three states: CLEAR, IDLE, RESP.
- **CLEAR**
  - Entered on reset.
  - A word counter writes 0 to word 0 .. DEPTH-1, one word per cycle.
  - req_ready=0 throughout.
  - After the word DEPTH-1 write, go to IDLE and set init_done=1, which stays 1 until the next reset.
- **IDLE**
  - req_ready=1.
  - On accept (req_valid & req_ready), go to RESP.
- **RESP**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - req_ready = rsp_ready, so back-to-back accepts are allowed.
  - On rsp_ready: with a new accept, stay in RESP with the new response; without one, go to IDLE.
- **Address decode**
  - Word index = req_addr >> log2(XLEN/8).
  - Byte offset = low log2(XLEN/8) bits.
  - Little-endian byte order.
- **Errors** — rsp_err=1, rsp_rdata=0, and memory is not modified, when any of:
  - offset is not a multiple of the access size (2^req_size bytes);
  - word index >= DEPTH, with the upper address bits checked;
  - req_size=3 while XLEN=32.
- **Stores**
  - Only the 2^size addressed bytes are written, with a byte-enable on the word.
  - Data comes from req_wdata[8·2^size-1:0], shifted to the offset.
- **Loads**
  - Extract the addressed bytes.
  - Sign-extend from the top bit of the access unless req_unsigned; ignore req_unsigned for size == XLEN.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, clear counter=0, state=CLEAR.
- Reset asserted mid-operation:
  - any pending response is dropped;
  - the sweep restarts at word 0 after rst_n deasserts;
  - memory contents during the sweep are don't-care.
- Latency: accept at edge N gives rsp_valid from N (visible in cycle N+1). The store write and the load read both occur at that accept edge.
- Load accepted at the edge after a store accept to the same word returns the stored bytes (no forwarding needed; the write is committed first).
- Sweep duration: exactly DEPTH cycles from the first clk edge after rst_n rises to init_done=1.
- A load and a store are never in flight together; one accept per cycle maximum.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state enum (CLEAR, IDLE, RESP);
  - a function giving the byte count for a size.
- Sub-module dmem_lane_align (combinational):
  - store path: byte-enable generation and write-data shift;
  - load path: byte extract and sign/zero extend;
  - parametrised by XLEN.
- Storage is one reg array of DEPTH × XLEN with per-byte write enables. The top level owns the FSM, the counter and the error decode.

## Test plan
- Reset, then count cycles → init_done rises exactly DEPTH cycles after rst_n release; req_ready=0 until then; a read of word 5 returns 0.
- XLEN=64 store: SD 0x1122334455667788 @0x8, then SB 0xAA @0xB → LD @0x8 = 0x11223344AA667788; LB @0xB = 0xFFFFFFFFFFFFFFAA; LBU @0xB = 0xAA.
- LH @0x9 → rsp_err=1, rsp_rdata=0, no write. SW @0x2002 with DEPTH=1024 → rsp_err=1 and memory unchanged.
- Back-to-back traffic: hold rsp_ready=0 for 3 cycles after a load → rsp_valid/rsp_rdata stay stable and req_ready=0. Then raise rsp_ready with a new req_valid → the next response appears in the following cycle without a bubble.
- Assert rst_n=0 while in RESP → all outputs return to reset values at once, the sweep reruns, and previously stored data reads back as 0.
- XLEN=32 build: LW/LH/LB sign/zero cases pass; req_size=3 → rsp_err=1.
